net_tx_sched: RTL

//   Round-robin scheduler that shares the single RGMII frame transmitter among
//   N_REQ requesters. It grants one frame at a time and hands the winner's

---
 rtl/net_tx_sched.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/net_tx_sched.sv
// Round-robin scheduler sharing one RGMII frame transmitter among N_REQ sources.
// Pads short frames, drops oversize ones, enforces the IFG and a BUSY watchdog.
module net_tx_sched #(
    parameter int N_REQ   = 4,
    parameter int LEN_W   = 11,
    parameter int MIN_LEN = 46,
    parameter int MAX_LEN = 1500,
    parameter int IFG_CYC = 12,
    parameter int TMO_CYC = 2048
) (
    input  logic                       clk125,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*LEN_W-1:0]     req_len,
    output logic [N_REQ-1:0]           grant,
    output logic [N_REQ-1:0]           rej,
    output logic                       tx_start,
    output logic [$clog2(N_REQ)-1:0]   tx_src,
    output logic [LEN_W-1:0]           tx_len,
    input  logic                       tx_done,
    output logic                       tx_abort,
    output logic                       busy,
    output logic [15:0]                frm_cnt
);
    localparam int SW = $clog2(N_REQ);
    localparam int WW = $clog2(TMO_CYC);
    localparam int GW = $clog2(IFG_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_IFG
    } state_e;

    state_e           state_q, state_d;
    logic [SW-1:0]    ptr_q, ptr_d;
    logic [SW-1:0]    src_q, src_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] rej_q, rej_d;
    logic             start_q, start_d;
    logic             abort_q, abort_d;
    logic [WW-1:0]    wdog_q, wdog_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [15:0]      frm_cnt_q, frm_cnt_d;

    logic             win_vld;
    logic [SW-1:0]    win_idx;
    logic [LEN_W-1:0] win_len;
    logic             too_long;
    logic [LEN_W-1:0] pad_len;
    logic             arb;

    // Walk the ring backwards so the nearest requester after ptr ends up winning.
    always_comb begin
        int j;
        j       = 0;
        win_vld = 1'b0;
        win_idx = '0;
        win_len = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            j = (int'(ptr_q) + k) % N_REQ;
            if (req[j]) begin
                win_vld = 1'b1;
                win_idx = SW'(j);
                win_len = req_len[j*LEN_W +: LEN_W];
            end
        end
    end

    assign too_long = win_len > LEN_W'(MAX_LEN);
    assign pad_len  = (win_len < LEN_W'(MIN_LEN)) ? LEN_W'(MIN_LEN) : win_len;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        src_d     = src_q;
        len_d     = len_q;
        grant_d   = '0;
        rej_d     = '0;
        start_d   = 1'b0;
        abort_d   = 1'b0;
        wdog_d    = wdog_q;
        gap_d     = gap_q;
        frm_cnt_d = frm_cnt_q;
        arb       = 1'b0;
        unique case (state_q)
            S_IDLE: arb = 1'b1;
            S_START: begin
                state_d = S_BUSY;
                wdog_d  = '0;
            end
            S_BUSY: begin
                if (tx_done) begin
                    frm_cnt_d = frm_cnt_q + 16'd1;
                    gap_d     = GW'(IFG_CYC - 1);
                    state_d   = S_IFG;
                end else if (wdog_q == WW'(TMO_CYC - 1)) begin
                    abort_d = 1'b1;
                    gap_d   = GW'(IFG_CYC - 1);
                    state_d = S_IFG;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_IFG: begin
                // The last gap cycle doubles as the arbitration cycle.
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                    arb     = 1'b1;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
        endcase
        if (arb && win_vld) begin
            ptr_d = win_idx;
            if (too_long) begin
                rej_d[win_idx] = 1'b1;
            end else begin
                grant_d[win_idx] = 1'b1;
                start_d          = 1'b1;
                src_d            = win_idx;
                len_d            = pad_len;
                state_d          = S_START;
            end
        end
    end

    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= SW'(N_REQ - 1);
            src_q     <= '0;
            len_q     <= '0;
            grant_q   <= '0;
            rej_q     <= '0;
            start_q   <= 1'b0;
            abort_q   <= 1'b0;
            wdog_q    <= '0;
            gap_q     <= '0;
            frm_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            src_q     <= src_d;
            len_q     <= len_d;
            grant_q   <= grant_d;
            rej_q     <= rej_d;
            start_q   <= start_d;
            abort_q   <= abort_d;
            wdog_q    <= wdog_d;
            gap_q     <= gap_d;
            frm_cnt_q <= frm_cnt_d;
        end
    end

    assign grant    = grant_q;
    assign rej      = rej_q;
    assign tx_start = start_q;
    assign tx_src   = src_q;
    assign tx_len   = len_q;
    assign tx_abort = abort_q;
    assign busy     = (state_q != S_IDLE);
    assign frm_cnt  = frm_cnt_q;

endmodule
